fifo_flagged: RTL
=================

Name: fifo_flagged

Overview:
Parametrised synchronous FIFO that succeeds the basic single-clock FIFO. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. A first-word-fall-through (FWFT) read mode can be selected by parameter. It serves as the general-purpose buffer between producer and consumer blocks in the same clock domain.

Parameters:
B, 8, data width in bits
W, 4, address width; depth = 2^W entries
AF_THRESH, 2^W-2, almost_full asserts when level >= AF_THRESH (legal range 1..2^W)
AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH (legal range 0..2^W-1)
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
wr  input  1  write request
w_data  input  B  write data
rd  input  1  read request
r_data  output  B  read data
clr_err  input  1  synchronous clear of overflow/underflow
full  output  1  level == 2^W
empty  output  1  level == 0
almost_full  output  1  level >= AF_THRESH
almost_empty  output  1  level <= AE_THRESH
level  output  W+1  current occupancy, 0..2^W
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (reset=0, no clock needed): wr_ptr and rd_ptr go to 0; level=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, r_data=0. Memory contents are not reset.
- Pointers are W+1 bits and wrap modulo 2^(W+1). level = wr_ptr - rd_ptr. All flags decode from the registered pointers, so they change only at the clock edge of an accepted operation.
- Read accepted (rd_ok) when rd=1 and empty=0.
- Write accepted (wr_ok) when wr=1 and (full=0 or rd_ok=1). Full plus simultaneous rd and wr: both are accepted, and level stays 2^W.
- Empty plus simultaneous rd and wr: the write is accepted, the read is rejected, and underflow is set.
- wr_ok stores w_data at mem[wr_ptr[W-1:0]] and increments wr_ptr. rd_ok increments rd_ptr.
- FWFT=0: on rd_ok, r_data is loaded with mem[rd_ptr] at that edge, so it is valid one cycle after the read request. r_data holds its value otherwise, including while empty.
- FWFT=1: r_data continuously shows mem[rd_ptr[W-1:0]] and is valid whenever empty=0. A write into an empty FIFO appears on r_data after that write edge. rd_ok advances to the next entry. When empty, r_data is undefined, and the bench must not check it.
- Error flags:
  - overflow is set at the edge where wr=1, full=1 and rd_ok=0.
  - underflow is set at the edge where rd=1 and empty=1.
  - Both flags are sticky until clr_err=1 at a clock edge.
  - If clr_err is active in the same cycle as a new error, the set wins.
  - Rejected operations never move pointers or change memory.
- Reset asserted mid-operation: all outputs return to reset values immediately; in-flight data is discarded.

Test Plan:
- B=3, W=2, AF_THRESH=3, AE_THRESH=1, FWFT=0. Reset, then rd=1 for one cycle -> empty=1, level=0, r_data=0, underflow=1. Then clr_err=1 for one cycle -> underflow=0.
- Write 5, 6, 7, 0 on consecutive cycles:
  - level goes 1, 2, 3, 4.
  - almost_empty drops when level reaches 2.
  - almost_full rises at 3; full rises at 4.
  - A fifth write of 1 is rejected: overflow=1, level stays 4.
- While full, drive rd=1 and wr=1 with w_data=1 -> level stays 4 and r_data=5 the next cycle. Four further reads then give r_data 6, 7, 0, 1, and empty=1 after the last.
- Wrap-around: 12 alternating single writes and reads of values 0..7 repeating -> every read returns the value written, in order. level toggles 1/0, and no error flags are set.
- FWFT=1: write 3 into an empty FIFO -> after that edge empty=0 and r_data=3 with no rd. Write 4, then rd=1 -> r_data=4 and level=1.
- Mid-operation reset: with level=3, pull reset low between clock edges -> level=0, empty=1, full=0, overflow=0 and r_data=0 without a clock edge. Normal writes resume after reset is released.

Source files
------------

// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, and an optional FWFT read port.
module fifo_flagged #(
  parameter int B         = 8,
  parameter int W         = 4,
  parameter int AF_THRESH = 2**W - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  input  logic         clr_err,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);
  localparam int DEPTH = 2**W;
  localparam logic [W:0] DEPTH_L = {1'b1, {W{1'b0}}};
  localparam logic [W:0] AF_T    = AF_THRESH[W:0];
  localparam logic [W:0] AE_T    = AE_THRESH[W:0];

  logic [B-1:0] mem [DEPTH];
  logic [W:0]   wr_ptr, rd_ptr;
  logic         rd_ok, wr_ok;

  // Flags decode only from registered pointers, never from this cycle's requests.
  assign level        = wr_ptr - rd_ptr;
  assign full         = (level == DEPTH_L);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_T);
  assign almost_empty = (level <= AE_T);

  // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[W-1:0]] <= w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd_ok) overflow <= 1'b1;
      else if (clr_err)         overflow <= 1'b0;
      if (rd && empty)          underflow <= 1'b1;
      else if (clr_err)         underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is shown directly; forced to zero while empty so reset reads as 0.
      assign r_data = empty ? '0 : mem[rd_ptr[W-1:0]];
    end else begin : g_std
      logic [B-1:0] r_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)     r_q <= '0;
        else if (rd_ok) r_q <= mem[rd_ptr[W-1:0]];
      end
      assign r_data = r_q;
    end
  endgenerate
endmodule
